// File: rtl/isa_types.sv
// Shared ISA-level types: machine word width and memory write widths.
// Pure type/constant package, no logic.
// Imported by every block that talks to the memory port.
package isa_types;

    localparam int XLEN = 32;

    typedef enum logic [1:0] {
        write_byte = 2'd0,
        write_half = 2'd1,
        write_word = 2'd2
    } write_width_t;

endpackage

// File: rtl/mem_arb_types.sv
// Types shared by the memory arbiter and its grant picker.
// Pure type package, no logic.
// mem_req_t is the latched request payload; arb_state_t is the arbiter FSM.
package mem_arb_types;

    import isa_types::*;

    typedef struct packed {
        logic [XLEN-1:0] addr;
        logic            wenable;
        logic [XLEN-1:0] wdata;
        write_width_t    wwidth;
    } mem_req_t;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_READ  = 2'd1,
        ARB_WRITE = 2'd2,
        ARB_RESP  = 2'd3
    } arb_state_t;

endpackage

// File: rtl/mem_arb_grant.sv
// 2-way request picker producing a one-hot grant (round-robin, or fixed priority with MEM_ARB_FIXED_PRIORITY_EN).
// Latency: purely combinational.
// Backpressure: none of its own; grant is zero when no port is valid.
module mem_arb_grant (
    input  logic [1:0] req_valid,
    input  logic       last_grant,
    output logic [1:0] grant
);

    always_comb begin
        grant = req_valid;
        if (req_valid == 2'b11) begin
`ifdef MEM_ARB_FIXED_PRIORITY_EN
            grant = 2'b01;
`else
            // On a tie the port that did not win last time goes first.
            grant = last_grant ? 2'b01 : 2'b10;
`endif
        end
    end

`ifdef MEM_ARB_FIXED_PRIORITY_EN
    logic unused_last_grant;
    assign unused_last_grant = last_grant;
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Shares the single memory port between the hart (port 0) and a loader/debug engine (port 1); MEM_ARB_FIXED_PRIORITY_EN selects fixed priority.
// Latency: read resp_valid READ_LATENCY+2 cycles after acceptance, write ack 2 cycles after; one transaction at a time.
// Backpressure: req_ready only in ARB_IDLE for the granted valid port; requests are held until accepted.
module mem_arbiter
    import isa_types::*;
    import mem_arb_types::*;
#(
    parameter int READ_LATENCY = 2
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic [1:0]                 req_valid,
    output logic [1:0]                 req_ready,
    input  logic [1:0][XLEN-1:0]       req_addr,
    input  logic [1:0]                 req_wenable,
    input  logic [1:0][XLEN-1:0]       req_wdata,
    input  write_width_t [1:0]         req_wwidth,
    output logic [1:0]                 resp_valid,
    output logic [XLEN-1:0]            resp_rdata,
    output logic [XLEN-1:0]            mem_addr,
    output logic                       mem_wenable,
    output logic [XLEN-1:0]            mem_wdata,
    output write_width_t               mem_wwidth,
    input  logic [XLEN-1:0]            mem_rdata
);

    localparam int CNT_W = (READ_LATENCY < 1) ? 1 : $clog2(READ_LATENCY + 1);

    arb_state_t        state_q, state_d;
    logic [CNT_W-1:0]  count_q, count_d;
    mem_req_t          req_q, req_d;
    logic              port_q, port_d;
    logic [XLEN-1:0]   rdata_q, rdata_d;
    logic [1:0]        grant;
    logic              accept;
    logic              last_grant;

    mem_arb_grant u_grant (
        .req_valid  (req_valid),
        .last_grant (last_grant),
        .grant      (grant)
    );

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        req_d       = req_q;
        port_d      = port_q;
        rdata_d     = rdata_q;
        accept      = 1'b0;
        req_ready   = 2'b00;
        resp_valid  = 2'b00;
        mem_addr    = '0;
        mem_wenable = 1'b0;
        mem_wdata   = '0;
        mem_wwidth  = write_byte;

        case (state_q)
            ARB_IDLE: begin
                req_ready = grant;
                if (grant != 2'b00) begin
                    accept  = 1'b1;
                    port_d  = grant[1];
                    req_d   = '{addr:    req_addr[grant[1]],
                                wenable: req_wenable[grant[1]],
                                wdata:   req_wdata[grant[1]],
                                wwidth:  req_wwidth[grant[1]]};
                    count_d = CNT_W'(READ_LATENCY);
                    state_d = req_wenable[grant[1]] ? ARB_WRITE : ARB_READ;
                end
            end
            ARB_READ: begin
                mem_addr = req_q.addr;
                if (count_q != '0) begin
                    count_d = count_q - CNT_W'(1);
                end else begin
                    rdata_d = mem_rdata;
                    state_d = ARB_RESP;
                end
            end
            ARB_WRITE: begin
                mem_addr    = req_q.addr;
                mem_wdata   = req_q.wdata;
                mem_wwidth  = req_q.wwidth;
                mem_wenable = 1'b1;
                state_d     = ARB_RESP;
            end
            ARB_RESP: begin
                resp_valid[port_q] = 1'b1;
                state_d            = ARB_IDLE;
            end
            default: state_d = ARB_IDLE;
        endcase

        // Reset is synchronous, so the handshake outputs are masked while it is held.
        if (!reset_n) begin
            req_ready   = 2'b00;
            resp_valid  = 2'b00;
            mem_wenable = 1'b0;
        end
    end

    assign resp_rdata = rdata_q;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q <= ARB_IDLE;
            count_q <= '0;
            req_q   <= '0;
            port_q  <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            req_q   <= req_d;
            port_q  <= port_d;
            rdata_q <= rdata_d;
        end
    end

`ifdef MEM_ARB_FIXED_PRIORITY_EN
    assign last_grant = 1'b0;
`else
    logic last_grant_q, last_grant_d;

    always_comb begin
        last_grant_d = last_grant_q;
        if (accept) begin
            last_grant_d = grant[1];
        end
    end

    // Resets to port 1 so port 0 wins the first tie.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            last_grant_q <= 1'b1;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

    assign last_grant = last_grant_q;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a small latency-modelled memory and a response scoreboard.
module tb_mem_arbiter;

    import isa_types::*;

    localparam int RL = 2;

    logic                 clock = 1'b0;
    logic                 reset_n;
    logic [1:0]           req_valid;
    logic [1:0]           req_ready;
    logic [1:0][XLEN-1:0] req_addr;
    logic [1:0]           req_wenable;
    logic [1:0][XLEN-1:0] req_wdata;
    write_width_t [1:0]   req_wwidth;
    logic [1:0]           resp_valid;
    logic [XLEN-1:0]      resp_rdata;
    logic [XLEN-1:0]      mem_addr;
    logic                 mem_wenable;
    logic [XLEN-1:0]      mem_wdata;
    write_width_t         mem_wwidth;
    logic [XLEN-1:0]      mem_rdata;

    mem_arbiter #(.READ_LATENCY(RL)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_addr    (req_addr),
        .req_wenable (req_wenable),
        .req_wdata   (req_wdata),
        .req_wwidth  (req_wwidth),
        .resp_valid  (resp_valid),
        .resp_rdata  (resp_rdata),
        .mem_addr    (mem_addr),
        .mem_wenable (mem_wenable),
        .mem_wdata   (mem_wdata),
        .mem_wwidth  (mem_wwidth),
        .mem_rdata   (mem_rdata)
    );

    always #5 clock = ~clock;

    // Memory model: read data follows the address after RL register stages.
    logic [31:0] mem [0:63] = '{4: 32'hDEADBEEF, 5: 32'h11112222, default: 32'h0};
    logic [31:0] a1 = '0;
    logic [31:0] a2 = '0;
    always @(posedge clock) begin
        a1 <= mem_addr;
        a2 <= a1;
        if (mem_wenable) begin
            case (mem_wwidth)
                write_byte: mem[mem_addr[7:2]][{mem_addr[1:0], 3'b000} +: 8] <= mem_wdata[7:0];
                write_half: mem[mem_addr[7:2]][{mem_addr[1], 4'b0000} +: 16] <= mem_wdata[15:0];
                write_word: mem[mem_addr[7:2]] <= mem_wdata;
                default: ;
            endcase
        end
    end
    assign mem_rdata = mem[a2[7:2]];

    typedef struct {
        int          port;
        logic        wr;
        logic [31:0] rdata;
        int          lat;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   acc_cyc = 0;
    int   busy = 0;
    int   wen_cnt = 0;
    int   wen_cyc = 0;
    logic [31:0] wen_addr = '0;
    logic [31:0] wen_dat = '0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Monitor: handshake invariants, write strobe capture and scoreboard compare.
    always @(negedge clock) begin
        if (!reset_n) begin
            busy = 0;
        end else begin
            if (busy > 0) begin
                chk("ready_while_busy", 64'(req_ready), 64'd0);
                busy--;
            end
            if (req_ready != 2'b00) begin
                chk("ready_onehot_valid",
                    64'($onehot(req_ready) && ((req_ready & ~req_valid) == 2'b00)), 64'd1);
                acc_cyc = cyc + 1;
                busy = req_wenable[req_ready[1]] ? 2 : RL + 2;
            end
            if (mem_wenable) begin
                wen_cnt++;
                wen_addr = mem_addr;
                wen_dat  = mem_wdata;
                wen_cyc  = cyc;
            end
            if (resp_valid != 2'b00) begin
                if (sb.size() == 0) begin
                    chk("resp_unexpected", 64'(resp_valid), 64'd0);
                end else begin
                    mon_e = sb.pop_front();
                    chk("resp_port", 64'(resp_valid), 64'(2'b01 << mon_e.port));
                    chk("resp_latency", 64'(cyc - acc_cyc), 64'(mon_e.lat));
                    if (!mon_e.wr) chk("resp_rdata", 64'(resp_rdata), 64'(mon_e.rdata));
                end
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic setp(input int p, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input write_width_t w);
        req_addr[p]    = addr;
        req_wenable[p] = wr;
        req_wdata[p]   = wdata;
        req_wwidth[p]  = w;
    endtask

    task automatic expect_resp(input int p, input logic wr, input logic [31:0] rdata);
        exp_t e;
        e.port = p;
        e.wr = wr;
        e.rdata = rdata;
        e.lat = wr ? 1 : RL + 1;
        sb.push_back(e);
    endtask

    task automatic wait_accept(input int p);
        logic ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clock);
            ok = req_ready[p];
        end
        chk("accept", 64'(ok), 64'd1);
        step();
    endtask

    task automatic issue(input int p, input logic wr, input logic [31:0] addr,
                         input logic [31:0] wdata, input write_width_t w, input logic [31:0] rdata);
        expect_resp(p, wr, rdata);
        setp(p, wr, addr, wdata, w);
        req_valid[p] = 1'b1;
        wait_accept(p);
        req_valid[p] = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 60 && sb.size() != 0; i++) @(negedge clock);
        chk("drain", 64'(sb.size()), 64'd0);
        step();
    endtask

    task automatic hold_both(input int n);
        int seen = 0;
        req_valid = 2'b11;
        for (int i = 0; i < 40 * n && seen < n; i++) begin
            @(negedge clock);
            if (resp_valid != 2'b00) seen++;
        end
        req_valid = 2'b00;
        chk("hold_responses", 64'(seen), 64'(n));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int wen0;
        int rcyc;
        int quiet;
        logic got;

        reset_n     = 1'b0;
        req_valid   = 2'b00;
        req_addr    = '0;
        req_wenable = 2'b00;
        req_wdata   = '0;
        req_wwidth  = {write_byte, write_byte};
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        chk("rst_resp_valid", 64'(resp_valid), 64'd0);
        chk("rst_mem_wenable", 64'(mem_wenable), 64'd0);
        chk("rst_mem_addr", 64'(mem_addr), 64'd0);
        chk("rst_mem_wwidth", 64'(mem_wwidth), 64'(write_byte));
        chk("rst_resp_rdata", 64'(resp_rdata), 64'd0);
        step();
        reset_n = 1'b1;
        step();

        // Single read on port 0.
        issue(0, 1'b0, 32'h10, 32'h0, write_byte, 32'hDEADBEEF);
        drain();

        // Single byte write on port 1, then read it back on port 0.
        wen0 = wen_cnt;
        issue(1, 1'b1, 32'h20, 32'h000000AB, write_byte, 32'h0);
        drain();
        chk("wr_strobe_count", 64'(wen_cnt - wen0), 64'd1);
        chk("wr_addr", 64'(wen_addr), 64'h20);
        chk("wr_data", 64'(wen_dat), 64'hAB);
        chk("wr_strobe_cycle", 64'(wen_cyc), 64'(acc_cyc));
        issue(0, 1'b0, 32'h20, 32'h0, write_byte, 32'h000000AB);
        drain();
        issue(1, 1'b0, 32'h14, 32'h0, write_byte, 32'h11112222);
        drain();

        // Both ports held for six transactions.
        setp(0, 1'b0, 32'h10, 32'h0, write_byte);
        setp(1, 1'b0, 32'h14, 32'h0, write_byte);
        for (int i = 0; i < 6; i++) begin
`ifdef MEM_ARB_FIXED_PRIORITY_EN
            expect_resp(0, 1'b0, 32'hDEADBEEF);
`else
            if (i % 2 == 0) expect_resp(0, 1'b0, 32'hDEADBEEF);
            else            expect_resp(1, 1'b0, 32'h11112222);
`endif
        end
        hold_both(6);
        drain();

        // Reset during a port-0 read; the following tie must go to port 0.
        setp(0, 1'b0, 32'h10, 32'h0, write_byte);
        req_valid[0] = 1'b1;
        wait_accept(0);
        req_valid[0] = 1'b0;
        step();
        reset_n = 1'b0;
        @(negedge clock);
        chk("midrst_req_ready", 64'(req_ready), 64'd0);
        chk("midrst_resp_valid", 64'(resp_valid), 64'd0);
        chk("midrst_mem_wenable", 64'(mem_wenable), 64'd0);
        step();
        step();
        reset_n = 1'b1;
        quiet = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            if (resp_valid != 2'b00) quiet++;
        end
        chk("midrst_no_resp", 64'(quiet), 64'd0);
        step();
        setp(0, 1'b0, 32'h10, 32'h0, write_byte);
        setp(1, 1'b0, 32'h14, 32'h0, write_byte);
        expect_resp(0, 1'b0, 32'hDEADBEEF);
        hold_both(1);
        drain();

        // Back-to-back: new port-0 read raised in the resp_valid cycle.
        setp(0, 1'b0, 32'h10, 32'h0, write_byte);
        expect_resp(0, 1'b0, 32'hDEADBEEF);
        req_valid[0] = 1'b1;
        wait_accept(0);
        req_valid[0] = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clock);
            got = resp_valid[0];
        end
        chk("b2b_first_resp", 64'(got), 64'd1);
        rcyc = cyc;
        setp(0, 1'b0, 32'h14, 32'h0, write_byte);
        expect_resp(0, 1'b0, 32'h11112222);
        req_valid[0] = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clock);
            got = req_ready[0];
        end
        chk("b2b_accept_cycle", 64'(cyc), 64'(rcyc + 1));
        step();
        req_valid[0] = 1'b0;
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter that shares the single `memory` port between the hart (port 0) and a second requester such as a program loader or debug/DMA engine (port 1). It accepts one request at a time over a valid/ready handshake. It sequences the memory's fixed read latency and returns read data or a write acknowledgement with a one-cycle `resp_valid` pulse on the granted port. It sits between the requesters and the `memory` instance, and replaces the hart's direct drive of `mem_addr`/`mem_wenable`.

## Interface
Parameters:
- `READ_LATENCY`, default 2: extra cycles the memory address must be held before `mem_rdata` is valid.

Ports:
- `clock`  in  1  rising-edge clock.
- `reset_n`  in  1  synchronous reset, active-low.
- `req_valid[1:0]`  in  2  per-port request valid. Must be held, with its payload stable, until accepted.
- `req_ready[1:0]`  out  2  per-port accept. At most one bit is high in any cycle.
- `req_addr[1:0]`  in  2×XLEN  per-port byte address.
- `req_wenable[1:0]`  in  2  1 = write, 0 = read.
- `req_wdata[1:0]`  in  2×XLEN  per-port write data.
- `req_wwidth[1:0]`  in  2×write_width_t  per-port write width.
- `resp_valid[1:0]`  out  2  one-cycle completion pulse on the port that issued the request.
- `resp_rdata`  out  XLEN  read data. Valid while any `resp_valid` bit is high.
- `mem_addr`  out  XLEN  to `memory`.
- `mem_wenable`  out  1  to `memory`.
- `mem_wdata`  out  XLEN  to `memory`.
- `mem_wwidth`  out  write_width_t  to `memory`.
- `mem_rdata`  in  XLEN  from `memory`.

## Operation
- States: `ARB_IDLE`, `ARB_READ`, `ARB_WRITE`, `ARB_RESP`.
- ARB_IDLE:
  - `req_ready` is high for the granted port only, and only when that port's `req_valid` is high.
  - On acceptance, the payload (addr, wenable, wdata, wwidth) and the port index are latched.
  - Next state is ARB_WRITE if the request is a write, else ARB_READ with `count <= READ_LATENCY`.
- ARB_READ:
  - `mem_addr` is driven from the latched address; `mem_wenable` = 0.
  - If `count != 0`, decrement. If `count == 0`, capture `mem_rdata` into `resp_rdata` and go to ARB_RESP.
- ARB_WRITE:
  - `mem_addr`, `mem_wdata` and `mem_wwidth` are driven from the latch; `mem_wenable` = 1 for exactly this one cycle.
  - `resp_rdata` is unchanged. Next state is ARB_RESP.
- ARB_RESP:
  - `resp_valid[latched port]` = 1 and all `req_ready` bits = 0. Next state is ARB_IDLE.
- Grant policy (round-robin):
  - A `last_grant` register records the most recent grant.
  - If only one port is valid, that port wins.
  - If both are valid, the port that is not `last_grant` wins.
  - `last_grant` updates only on acceptance.
- Outside ARB_READ/ARB_WRITE, `mem_addr` = 0, `mem_wenable` = 0, `mem_wdata` = 0, `mem_wwidth` = write_byte.
- Addresses and widths pass through unmodified. Alignment is the memory's concern.
- Reset values:
  - state = ARB_IDLE, `last_grant` = 1 (so port 0 wins the first tie), `count` = 0.
  - `resp_rdata` = 0, `resp_valid` = 0, `req_ready` = 0 during reset, `mem_wenable` = 0.

## Timing
- With acceptance at edge N:
  - Read: address is driven in cycles N+1 … N+1+READ_LATENCY; data is captured at the end of cycle N+1+READ_LATENCY; `resp_valid` is high in cycle N+2+READ_LATENCY.
  - Write: `mem_wenable` is high in cycle N+1; `resp_valid` is high in cycle N+2.
- Occupancy: a read takes READ_LATENCY+3 cycles and a write takes 3 cycles, counted from acceptance cycle to return to ARB_IDLE. There is no overlap between transactions.
- A requester may present a new request in the cycle `resp_valid` is high. It is considered in the following ARB_IDLE cycle.
- If `req_valid` drops before acceptance, nothing is latched and that violates the protocol; the arbiter does not check for it.
- Reset asserted mid-transaction aborts the transaction: no `resp_valid` is issued and `mem_wenable` is deasserted in the next cycle.
- If `READ_LATENCY` = 0, ARB_READ lasts exactly one cycle.

## Configuration
- `MEM_ARB_FIXED_PRIORITY_EN`:
  - Defined: port 0 always wins ties, and `last_grant` is not instantiated.
  - Undefined (default): round-robin as described above.

## Structure
- Shared package `isa_types` supplies `XLEN` and `write_width_t`.
- Add `mem_req_t` (addr, wenable, wdata, wwidth) and `arb_state_t` to a shared package `mem_arb_types`.
- One sub-module, `mem_arb_grant`: a combinational 2-way picker taking `req_valid`, `last_grant` and the macro, and producing a one-hot grant.

## Test plan
- Read, port 0 only, READ_LATENCY=2:
  - Stimulus: addr 0x10, memory word 0xDEADBEEF.
  - Response: accepted at edge N; `resp_valid[0]` in cycle N+4; `resp_rdata` = 0xDEADBEEF; `resp_valid[1]` stays 0.
- Write, port 1 only:
  - Stimulus: addr 0x20, wdata 0x000000AB, write_byte.
  - Response: `mem_wenable` high for exactly one cycle with addr 0x20; `resp_valid[1]` the next cycle; a subsequent port-0 read of 0x20 returns 0xAB in the low byte.
- Both ports hold `req_valid` continuously for 6 transactions:
  - Round-robin build: grants alternate 0,1,0,1,0,1.
  - With `MEM_ARB_FIXED_PRIORITY_EN`: all six grants go to port 0.
- Reset mid-transaction:
  - Stimulus: `reset_n` low in cycle N+2 of a read.
  - Response: no `resp_valid`; state ARB_IDLE; next tie is granted to port 0.
- Back-to-back:
  - Stimulus: port 0 raises a new read in its `resp_valid` cycle.
  - Response: accepted in the next cycle; `req_ready` is never high in ARB_READ, ARB_WRITE or ARB_RESP.
